// File: rtl/square_game_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : square_game_ctrl
// Purpose  : Frame-synchronous player-square / single-shot controller.
//            Optional build macro AUTOFIRE_EN: level-triggered launch in READY.
// Revision : 1.0 - initial release
// ============================================================================
module square_game_ctrl #(
    parameter int H_RES           = 640,
    parameter int V_RES           = 480,
    parameter int SQ_SIZE         = 10,
    parameter int SQ_X            = 315,
    parameter int STEP            = 4,
    parameter int SHOT_SPEED      = 8,
    parameter int COOLDOWN_FRAMES = 15
) (
    input  logic        clk_pix,
    input  logic        sim_rst,
    input  logic        frame_tick,
    input  logic        btn_up,
    input  logic        btn_dn,
    input  logic        btn_fire,
    output logic [9:0]  sq_y,
    output logic [9:0]  shot_x,
    output logic [9:0]  shot_y,
    output logic        shot_active,
    output logic [1:0]  ctrl_state,
    output logic [15:0] frame_count
);

    localparam logic [1:0]  c_ST_READY    = 2'd0;
    localparam logic [1:0]  c_ST_FLIGHT   = 2'd1;
    localparam logic [1:0]  c_ST_COOLDOWN = 2'd2;

    localparam int          c_CNT_W       = $clog2(COOLDOWN_FRAMES + 1);
    localparam logic [c_CNT_W-1:0] c_CD_LOAD = c_CNT_W'(COOLDOWN_FRAMES);
    localparam logic [c_CNT_W-1:0] c_CD_ONE  = c_CNT_W'(1);

    localparam logic [9:0]  c_SQ_Y_RESET  = 10'((V_RES - SQ_SIZE) / 2);
    localparam logic [10:0] c_SQ_Y_MAX    = 11'(V_RES - SQ_SIZE);
    localparam logic [10:0] c_STEP        = 11'(STEP);
    localparam logic [10:0] c_SPEED       = 11'(SHOT_SPEED);
    localparam logic [10:0] c_H_RES       = 11'(H_RES);
    localparam logic [9:0]  c_SHOT_X0     = 10'(SQ_X + SQ_SIZE);

    logic               r_up_meta, r_up_sync;
    logic               r_dn_meta, r_dn_sync;
    logic               r_fire_meta, r_fire_sync;
    logic               r_fire_prev;
    logic               r_fire_armed;
    logic [c_CNT_W-1:0] r_cd_cnt;

    logic [10:0]        w_sq_dec;
    logic [10:0]        w_sq_inc;
    logic [10:0]        w_shot_adv;
    logic [9:0]         w_sq_y_next;
    logic               w_launch;

    // 11-bit arithmetic: bit 10 of the decrement is the underflow borrow.
    always_comb begin
        w_sq_dec    = {1'b0, sq_y} - c_STEP;
        w_sq_inc    = {1'b0, sq_y} + c_STEP;
        w_shot_adv  = {1'b0, shot_x} + c_SPEED;
        w_sq_y_next = sq_y;
        if (r_up_sync && !r_dn_sync) begin
            w_sq_y_next = w_sq_dec[10] ? 10'd0 : w_sq_dec[9:0];
        end else if (r_dn_sync && !r_up_sync) begin
            w_sq_y_next = (w_sq_inc > c_SQ_Y_MAX) ? c_SQ_Y_MAX[9:0] : w_sq_inc[9:0];
        end
    end

`ifdef AUTOFIRE_EN
    always_comb w_launch = r_fire_sync;
`else
    // The first tick after reset only re-captures fire_prev, so a button held
    // through reset never counts as a fresh press.
    always_comb w_launch = r_fire_armed && r_fire_sync && !r_fire_prev;
`endif

    always_ff @(posedge clk_pix) begin
        if (sim_rst) begin
            r_up_meta    <= 1'b0;
            r_up_sync    <= 1'b0;
            r_dn_meta    <= 1'b0;
            r_dn_sync    <= 1'b0;
            r_fire_meta  <= 1'b0;
            r_fire_sync  <= 1'b0;
            r_fire_prev  <= 1'b0;
            r_fire_armed <= 1'b0;
            r_cd_cnt     <= '0;
            sq_y         <= c_SQ_Y_RESET;
            shot_x       <= 10'd0;
            shot_y       <= 10'd0;
            shot_active  <= 1'b0;
            ctrl_state   <= c_ST_READY;
            frame_count  <= 16'd0;
        end else begin
            r_up_meta   <= btn_up;
            r_up_sync   <= r_up_meta;
            r_dn_meta   <= btn_dn;
            r_dn_sync   <= r_dn_meta;
            r_fire_meta <= btn_fire;
            r_fire_sync <= r_fire_meta;

            if (frame_tick) begin
                frame_count  <= frame_count + 16'd1;
                r_fire_prev  <= r_fire_sync;
                r_fire_armed <= 1'b1;
                sq_y         <= w_sq_y_next;

                case (ctrl_state)
                    c_ST_READY: begin
                        if (w_launch) begin
                            ctrl_state  <= c_ST_FLIGHT;
                            shot_x      <= c_SHOT_X0;
                            shot_y      <= sq_y;
                            shot_active <= 1'b1;
                        end
                    end
                    c_ST_FLIGHT: begin
                        if (w_shot_adv >= c_H_RES) begin
                            ctrl_state  <= c_ST_COOLDOWN;
                            shot_active <= 1'b0;
                            r_cd_cnt    <= c_CD_LOAD;
                        end else begin
                            shot_x <= w_shot_adv[9:0];
                        end
                    end
                    c_ST_COOLDOWN: begin
                        r_cd_cnt <= r_cd_cnt - c_CD_ONE;
                        if (r_cd_cnt <= c_CD_ONE) begin
                            r_cd_cnt   <= '0;
                            ctrl_state <= c_ST_READY;
                        end
                    end
                    default: begin
                        ctrl_state  <= c_ST_READY;
                        shot_active <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_square_game_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_square_game_ctrl
// Purpose  : Scoreboard bench for square_game_ctrl against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_square_game_ctrl;

    localparam int H_RES = 640, V_RES = 480, SQ_SIZE = 10, SQ_X = 315;
    localparam int STEP = 4, SHOT_SPEED = 8, COOLDOWN_FRAMES = 15;
`ifdef AUTOFIRE_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic        clk_pix = 1'b0;
    logic        sim_rst = 1'b0;
    logic        frame_tick = 1'b0;
    logic        btn_up = 1'b0, btn_dn = 1'b0, btn_fire = 1'b0;
    logic [9:0]  sq_y, shot_x, shot_y;
    logic        shot_active;
    logic [1:0]  ctrl_state;
    logic [15:0] frame_count;

    square_game_ctrl dut (
        .clk_pix     (clk_pix),
        .sim_rst     (sim_rst),
        .frame_tick  (frame_tick),
        .btn_up      (btn_up),
        .btn_dn      (btn_dn),
        .btn_fire    (btn_fire),
        .sq_y        (sq_y),
        .shot_x      (shot_x),
        .shot_y      (shot_y),
        .shot_active (shot_active),
        .ctrl_state  (ctrl_state),
        .frame_count (frame_count)
    );

    always #5 clk_pix = ~clk_pix;

    typedef struct {
        int sq, sx, sy, act, st, fc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Frame-level reference state
    int m_sq, m_sx, m_sy, m_act, m_st, m_fc, m_prev, m_armed;
    int tick_no = 0;
    int ready_tick = 0;

    task automatic chk(input string name, input logic [15:0] act, input int exp);
        n_checks++;
        if (act !== 16'(exp)) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit up, input bit dn, input bit fire);
        exp_t e;
        int   old_sq;
        if (rst) begin
            m_sq = (V_RES - SQ_SIZE) / 2; m_sx = 0; m_sy = 0; m_act = 0;
            m_st = 0; m_fc = 0; m_prev = 0; m_armed = 0;
        end else begin
            old_sq = m_sq;
            tick_no++;
            if (m_st == 0) begin
                if (fire && (AUTO || (m_armed != 0 && m_prev == 0))) begin
                    m_st = 1; m_sx = SQ_X + SQ_SIZE; m_sy = old_sq; m_act = 1;
                end
            end else if (m_st == 1) begin
                if (m_sx + SHOT_SPEED >= H_RES) begin
                    m_st = 2; m_act = 0; ready_tick = tick_no + COOLDOWN_FRAMES;
                end else begin
                    m_sx += SHOT_SPEED;
                end
            end else if (tick_no == ready_tick) begin
                m_st = 0;
            end
            m_prev  = fire;
            m_armed = 1;
            if (up && !dn)      m_sq = (old_sq - STEP < 0) ? 0 : old_sq - STEP;
            else if (dn && !up) m_sq = (old_sq + STEP > V_RES - SQ_SIZE) ? V_RES - SQ_SIZE : old_sq + STEP;
            m_fc = (m_fc + 1) % 65536;
        end
        e = '{sq: m_sq, sx: m_sx, sy: m_sy, act: m_act, st: m_st, fc: m_fc};
        sb.push_back(e);
    endtask

    // One frame: buttons settle well before the tick so the synchroniser has filled.
    task automatic do_frame(input bit up, input bit dn, input bit fire, input bit rst);
        @(negedge clk_pix);
        btn_up = up; btn_dn = dn; btn_fire = fire;
        repeat (5) @(negedge clk_pix);
        frame_tick = 1'b1;
        sim_rst    = rst;
        model_step(rst, up, dn, fire);
        @(negedge clk_pix);
        frame_tick = 1'b0;
        sim_rst    = 1'b0;
    endtask

    // Monitor: after each tick/reset edge pop and compare; between events the
    // outputs must hold the last expected values.
    bit   mon_ev;
    bit   started = 1'b0;
    exp_t last;
    always begin
        @(posedge clk_pix);
        mon_ev = frame_tick | sim_rst;
        @(negedge clk_pix);
        if (mon_ev) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 16'd1, 0);
            end else begin
                last    = sb.pop_front();
                started = 1'b1;
            end
        end
        if (started) begin
            chk("sq_y",        16'(sq_y),        last.sq);
            chk("shot_x",      16'(shot_x),      last.sx);
            chk("shot_y",      16'(shot_y),      last.sy);
            chk("shot_active", 16'(shot_active), last.act);
            chk("ctrl_state",  16'(ctrl_state),  last.st);
            chk("frame_count", frame_count,      last.fc);
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held 3 cycles with frame_tick pulsing
        repeat (3) begin
            @(negedge clk_pix);
            sim_rst = 1'b1; frame_tick = 1'b1;
            model_step(1'b1, 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk_pix);
        sim_rst = 1'b0; frame_tick = 1'b0;

        repeat (60) do_frame(1'b0, 1'b1, 1'b0, 1'b0);   // down saturation
        repeat (120) do_frame(1'b1, 1'b0, 1'b0, 1'b0);  // up saturation
        repeat (3) do_frame(1'b1, 1'b1, 1'b0, 1'b0);    // contention hold

        // Flight/cooldown with fire toggling mid-flight, then held through READY
        do_frame(1'b0, 1'b0, 1'b0, 1'b0);
        do_frame(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) do_frame(1'b0, 1'b1, 1'(i % 2), 1'b0);
        repeat (45) do_frame(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (60) do_frame(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset mid-flight with fire held, then fire still held
        do_frame(1'b0, 1'b0, 1'b1, 1'b0);
        while (m_st == 1 && m_sx < 397) do_frame(1'b0, 1'b0, 1'b1, 1'b0);
        do_frame(1'b0, 1'b0, 1'b1, 1'b1);
        repeat (3) do_frame(1'b0, 1'b0, 1'b1, 1'b0);

        // Randomised frames
        for (int i = 0; i < 400; i++) begin
            do_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), ($urandom_range(0, 59) == 0));
        end

        repeat (4) @(negedge clk_pix);
        chk("sb_drain", 16'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
